// File: rtl/periph_hub.sv
// periph_hub: per-channel command FIFOs feeding IDLE/ISSUE/WAIT issue FSMs,
// with sticky completion (pend) / timeout (err) flags and a registered irq.
// Optional feature macro: PERIPH_HUB_DROP_CNT_EN enables the saturating
// dropped-write counter on drop_cnt; otherwise drop_cnt is tied to zero.

module periph_hub_ch #(
    parameter int PW      = 24,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [PW-1:0] push_data,
    input  logic          rdy,
    input  logic          irq_ack,
    output logic          full,
    output logic          start,
    output logic [PW-1:0] dout,
    output logic          pend,
    output logic          err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLIM   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CDEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   wcnt;
    logic            push_ok, pop, done, tmo;

    // Full is judged on the registered count, so a same-cycle pop never
    // rescues a write aimed at a full FIFO.
    assign full    = (cnt == CDEPTH);
    assign push_ok = push && !full;
    assign pop     = (state == IDLE) && (cnt != '0);
    assign start   = (state == ISSUE);

    // Next-state logic; rdy only matters in WAIT, and rdy beats a timeout.
    always_comb begin
        state_n = state;
        done    = 1'b0;
        tmo     = 1'b0;
        case (state)
            IDLE:  if (pop) state_n = ISSUE;
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (rdy) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (TIMEOUT > 0 && wcnt == TLIM) begin
                    tmo     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register and WAIT-cycle counter (zero whenever not waiting).
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= (state == WAIT && state_n == WAIT && TIMEOUT > 0) ? wcnt + TW'(1) : '0;
        end
    end

    // FIFO storage; validity is tracked by cnt, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= push_data;
    end

    // Wrapping pointers plus an explicit occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop)     rptr <= rptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload register: loaded on pop, held until the next pop.
    always_ff @(posedge clk) begin
        if (rst)      dout <= '0;
        else if (pop) dout <= mem[rptr];
    end

    // Sticky flags; a set in the same cycle wins over irq_ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            err  <= 1'b0;
        end else begin
            pend <= done | (pend & ~irq_ack);
            err  <= tmo  | (err  & ~irq_ack);
        end
    end
endmodule

module periph_hub #(
    parameter int CH_W    = 2,
    parameter int PW      = 24,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic [PW-1:0]             wr_data,
    output logic [(2**CH_W)-1:0]      full,
    output logic [(2**CH_W)-1:0]      start,
    output logic [(2**CH_W)*PW-1:0]   dout,
    input  logic [(2**CH_W)-1:0]      rdy,
    input  logic [(2**CH_W)-1:0]      irq_ack,
    output logic [(2**CH_W)-1:0]      pend,
    output logic [(2**CH_W)-1:0]      err,
    output logic                      irq,
    output logic [7:0]                drop_cnt
);
    localparam int N = 2**CH_W;

    for (genvar c = 0; c < N; c++) begin : g_ch
        periph_hub_ch #(.PW(PW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .push      (wr && (wr_ch == CH_W'(c))),
            .push_data (wr_data),
            .rdy       (rdy[c]),
            .irq_ack   (irq_ack[c]),
            .full      (full[c]),
            .start     (start[c]),
            .dout      (dout[c*PW +: PW]),
            .pend      (pend[c]),
            .err       (err[c])
        );
    end

    // Interrupt is registered from the sticky flags.
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= (|pend) | (|err);
    end

`ifdef PERIPH_HUB_DROP_CNT_EN
    logic dropped;
    assign dropped = wr && full[wr_ch];

    // Saturating count of writes refused because the target FIFO was full.
    always_ff @(posedge clk) begin
        if (rst)                              drop_cnt <= '0;
        else if (dropped && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
`else
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_periph_hub.sv
// Directed bench for periph_hub (CH_W=2, PW=24, DEPTH=4, TIMEOUT=8):
// a vector table for the single-command paths plus hand sequences for
// full/drop, timeout, reset mid-WAIT and concurrent multi-channel traffic.
module tb_periph_hub;
    logic        clk, rst, wr;
    logic [1:0]  wr_ch;
    logic [23:0] wr_data;
    logic [3:0]  full, start, rdy, irq_ack, pend, err;
    logic [95:0] dout;
    logic        irq;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

`ifdef PERIPH_HUB_DROP_CNT_EN
    localparam logic [7:0] D_EXP = 8'd1;
`else
    localparam logic [7:0] D_EXP = 8'd0;
`endif

    periph_hub #(.CH_W(2), .PW(24), .DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .wr(wr), .wr_ch(wr_ch), .wr_data(wr_data),
        .full(full), .start(start), .dout(dout), .rdy(rdy), .irq_ack(irq_ack),
        .pend(pend), .err(err), .irq(irq), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: inputs set beforehand are sampled, outputs settle, pulses drop.
    task automatic step();
        @(posedge clk);
        #1;
        rst = 0; wr = 0; rdy = 0; irq_ack = 0;
    endtask

    task automatic do_wr(input logic [1:0] ch, input logic [23:0] d);
        wr = 1; wr_ch = ch; wr_data = d;
        step();
    endtask

    task automatic wait_start(input int ch, input logic [23:0] d, input string name, output int lat);
        int found = 0;
        lat = -1;
        for (int n = 0; n < 6; n++) begin
            step();
            if (start[ch]) begin found = 1; lat = n; break; end
        end
        chk({name, "_start"}, 96'(found), 96'd1);
        if (found != 0) chk({name, "_dout"}, 96'(dout[ch*24 +: 24]), 96'(d));
    endtask

    // From ISSUE: one cycle into WAIT, then a rdy pulse.
    task automatic serve(input int ch);
        step();
        rdy[ch] = 1'b1;
        step();
    endtask

    typedef struct {
        logic        rst, wr;
        logic [1:0]  ch;
        logic [23:0] data;
        logic [3:0]  rdy, ack, e_start, e_pend, e_err;
        logic        e_irq;
        logic [3:0]  e_full;
        logic [95:0] e_dout;
    } vec_t;

    vec_t vt[17];
    logic [95:0] d2, d23;
    logic [23:0] q[4][$];
    int nst[4];
    int lat;

    initial begin
        rst = 0; wr = 0; wr_ch = 0; wr_data = 0; rdy = 0; irq_ack = 0;
        d2  = {24'h0, 24'hABCDEF, 48'h0};
        d23 = {24'h123456, 24'hABCDEF, 48'h0};
        //           rst wr ch     data          rdy      ack      start    pend     err     irq   full     dout
        vt[0]  = '{1'b1, 1'b1, 2'd2, 24'h111111, 4'hF,    4'hF,    4'h0,    4'h0,    4'h0,   1'b0, 4'h0,    96'h0};
        vt[1]  = '{1'b0, 1'b0, 2'd0, 24'h0,      4'h0,    4'h0,    4'h0,    4'h0,    4'h0,   1'b0, 4'h0,    96'h0};
        vt[2]  = '{1'b0, 1'b1, 2'd2, 24'hABCDEF, 4'h0,    4'h0,    4'h0,    4'h0,    4'h0,   1'b0, 4'h0,    96'h0};
        vt[3]  = '{1'b0, 1'b0, 2'd0, 24'h0,      4'h0,    4'h0,    4'b0100, 4'h0,    4'h0,   1'b0, 4'h0,    d2};
        vt[4]  = '{1'b0, 1'b0, 2'd0, 24'h0,      4'b0100, 4'h0,    4'h0,    4'h0,    4'h0,   1'b0, 4'h0,    d2};
        vt[5]  = '{1'b0, 1'b0, 2'd0, 24'h0,      4'h0,    4'h0,    4'h0,    4'h0,    4'h0,   1'b0, 4'h0,    d2};
        vt[6]  = '{1'b0, 1'b0, 2'd0, 24'h0,      4'b0100, 4'h0,    4'h0,    4'b0100, 4'h0,   1'b0, 4'h0,    d2};
        vt[7]  = '{1'b0, 1'b0, 2'd0, 24'h0,      4'h0,    4'h0,    4'h0,    4'b0100, 4'h0,   1'b1, 4'h0,    d2};
        vt[8]  = '{1'b0, 1'b0, 2'd0, 24'h0,      4'h0,    4'b0100, 4'h0,    4'h0,    4'h0,   1'b1, 4'h0,    d2};
        vt[9]  = '{1'b0, 1'b0, 2'd0, 24'h0,      4'h0,    4'h0,    4'h0,    4'h0,    4'h0,   1'b0, 4'h0,    d2};
        vt[10] = '{1'b0, 1'b1, 2'd3, 24'h123456, 4'h0,    4'h0,    4'h0,    4'h0,    4'h0,   1'b0, 4'h0,    d2};
        vt[11] = '{1'b0, 1'b0, 2'd0, 24'h0,      4'h0,    4'h0,    4'b1000, 4'h0,    4'h0,   1'b0, 4'h0,    d23};
        vt[12] = '{1'b0, 1'b0, 2'd0, 24'h0,      4'h0,    4'h0,    4'h0,    4'h0,    4'h0,   1'b0, 4'h0,    d23};
        vt[13] = '{1'b0, 1'b0, 2'd0, 24'h0,      4'b1000, 4'b1000, 4'h0,    4'b1000, 4'h0,   1'b0, 4'h0,    d23};
        vt[14] = '{1'b0, 1'b0, 2'd0, 24'h0,      4'h0,    4'h0,    4'h0,    4'b1000, 4'h0,   1'b1, 4'h0,    d23};
        vt[15] = '{1'b0, 1'b0, 2'd0, 24'h0,      4'h0,    4'hF,    4'h0,    4'h0,    4'h0,   1'b1, 4'h0,    d23};
        vt[16] = '{1'b0, 1'b0, 2'd0, 24'h0,      4'h0,    4'h0,    4'h0,    4'h0,    4'h0,   1'b0, 4'h0,    d23};

        #2;
        for (int i = 0; i < 17; i++) begin
            rst = vt[i].rst; wr = vt[i].wr; wr_ch = vt[i].ch; wr_data = vt[i].data;
            rdy = vt[i].rdy; irq_ack = vt[i].ack;
            step();
            chk($sformatf("v%0d_start", i), 96'(start), 96'(vt[i].e_start));
            chk($sformatf("v%0d_pend", i),  96'(pend),  96'(vt[i].e_pend));
            chk($sformatf("v%0d_err", i),   96'(err),   96'(vt[i].e_err));
            chk($sformatf("v%0d_irq", i),   96'(irq),   96'(vt[i].e_irq));
            chk($sformatf("v%0d_full", i),  96'(full),  96'(vt[i].e_full));
            chk($sformatf("v%0d_dout", i),  dout,       vt[i].e_dout);
            chk($sformatf("v%0d_drop", i),  96'(drop_cnt), 96'd0);
        end

        // Fill ch0 while it waits; the fifth write is dropped.
        do_wr(2'd0, 24'hA00000);
        wait_start(0, 24'hA00000, "fill_first", lat);
        for (int k = 1; k <= 5; k++) begin
            do_wr(2'd0, 24'(k));
            if (k == 3) chk("fill_full3", 96'(full), 96'h0);
            if (k == 4) chk("fill_full4", 96'(full), 96'h1);
            if (k == 5) begin
                chk("fill_full5", 96'(full), 96'h1);
                chk("fill_drop", 96'(drop_cnt), 96'(D_EXP));
            end
        end
        rdy[0] = 1'b1;
        step();
        chk("fill_pend", 96'(pend), 96'h1);
        for (int k = 1; k <= 4; k++) begin
            wait_start(0, 24'(k), $sformatf("fill_q%0d", k), lat);
            chk($sformatf("fill_lat%0d", k), 96'(lat), 96'd0);
            serve(0);
        end
        step(); step(); step();
        chk("fill_nomore", 96'(start), 96'h0);
        chk("fill_empty", 96'(full), 96'h0);
        irq_ack = 4'hF;
        step();

        // Timeout on ch1 after 8 WAIT cycles with no rdy.
        do_wr(2'd1, 24'h0000B1);
        wait_start(1, 24'h0000B1, "to", lat);
        step();
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 7) chk("to_err7", 96'(err), 96'h0);
            if (i == 8) begin
                chk("to_err8", 96'(err), 96'h2);
                chk("to_pend8", 96'(pend), 96'h0);
            end
        end
        step();
        chk("to_irq", 96'(irq), 96'd1);
        irq_ack[1] = 1'b1;
        step();
        chk("to_ack", 96'(err), 96'h0);
        do_wr(2'd1, 24'h0000B2);
        wait_start(1, 24'h0000B2, "to_next", lat);
        chk("to_next_lat", 96'(lat), 96'd0);
        serve(1);
        irq_ack = 4'hF;
        step();

        // Concurrent round-robin traffic; each FIFO pointer wraps 3+ times.
        for (int cyc = 0; cyc < 70; cyc++) begin
            if (cyc < 52) begin
                wr = 1; wr_ch = 2'(cyc % 4);
                wr_data = {6'd0, 2'(cyc % 4), 8'(cyc / 4), 8'($urandom)};
                q[cyc % 4].push_back(wr_data);
            end
            rdy = 4'hF;
            step();
            for (int c = 0; c < 4; c++) begin
                if (start[c]) begin
                    nst[c]++;
                    if (q[c].size() == 0) chk($sformatf("rr_extra%0d", c), 96'd1, 96'd0);
                    else chk($sformatf("rr_dout%0d", c), 96'(dout[c*24 +: 24]), 96'(q[c].pop_front()));
                end
            end
        end
        for (int c = 0; c < 4; c++) chk($sformatf("rr_count%0d", c), 96'(nst[c]), 96'd13);
        chk("rr_err", 96'(err), 96'h0);
        chk("rr_drop", 96'(drop_cnt), 96'(D_EXP));
        irq_ack = 4'hF;
        step();

        // Reset mid-WAIT with rdy and a write in the same cycle.
        do_wr(2'd0, 24'h0000C0);
        wait_start(0, 24'h0000C0, "rst", lat);
        step();
        rst = 1; rdy = 4'hF; wr = 1; wr_ch = 2'd1; wr_data = 24'h0000C9;
        step();
        chk("rst_start", 96'(start), 96'h0);
        chk("rst_pend", 96'(pend), 96'h0);
        chk("rst_err", 96'(err), 96'h0);
        chk("rst_irq", 96'(irq), 96'd0);
        chk("rst_full", 96'(full), 96'h0);
        chk("rst_dout", dout, 96'h0);
        chk("rst_drop", 96'(drop_cnt), 96'd0);
        step();
        chk("rst_pend2", 96'(pend), 96'h0);
        chk("rst_start2", 96'(start), 96'h0);
        do_wr(2'd0, 24'h0000C1);
        chk("rst_lat1", 96'(start), 96'h0);
        wait_start(0, 24'h0000C1, "rst_new", lat);
        chk("rst_new_lat", 96'(lat), 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
